if_fetch_stage: RTL and testbench
=================================

# if_fetch_stage

Instruction-fetch stage of the 5-stage pipelined CPU: it owns the program counter, fetches from instruction memory over a req/ack handshake that tolerates wait states, and drives the `instr`/`pc` inputs of the IF/ID pipeline buffer. It honours a hazard stall from decode and a branch/jump redirect from later stages. Bubbles are emitted as a NOP instruction, so the IF/ID buffer needs no valid bit.

## Interface
- `RESET_PC`, 32'h0: PC loaded on reset.
- `PC_STEP`, 1: PC increment per fetched instruction (word-addressed imem).
- `NOP_INSTR`, 32'h0: encoding driven on `instr_out` during a bubble.

- `clk` input 1: single clock; all state updates on posedge.
- `rst_n` input 1: asynchronous, active-low reset.
- `stall` input 1: decode hazard; hold IF/ID outputs.
- `redirect_valid` input 1: taken branch/jump; flush and load `redirect_pc`.
- `redirect_pc` input 32: redirect target.
- `imem_req` output 1: fetch request.
- `imem_addr` output 32: fetch address; stable while `imem_req`=1 and no ack.
- `imem_ack` input 1: data valid this cycle; meaningful only while `imem_req`=1.
- `imem_rdata` input 32: instruction word, valid with `imem_ack`.
- `instr_out` output 32: instruction to IF/ID.
- `pc_out` output 32: address of `instr_out`.
- `valid_out` output 1: 1 = real instruction, 0 = bubble.

## Operation
- Registers: `pc`, `pending_pc` (redirect target held during DRAIN), `skid_instr`/`skid_pc` (one-entry skid), FSM state, output registers.
- States: IDLE, FETCH, HOLD, DRAIN. `imem_req` = (FETCH or DRAIN). `imem_addr` = `pc`.
- IDLE: exits to FETCH unconditionally after one cycle. A redirect while in IDLE loads `pc`.
- FETCH:
  - Ack and not stall: `instr_out`<=rdata, `pc_out`<=pc, `valid_out`<=1, `pc`<=pc+PC_STEP. Stay in FETCH with `req` still high, giving back-to-back fetch.
  - Ack and stall: outputs hold; skid<=(rdata, pc); `pc`<=pc+PC_STEP; go to HOLD.
  - No ack and not stall: bubble (`instr_out`<=NOP_INSTR, `valid_out`<=0, `pc_out` holds).
  - No ack and stall: outputs hold.
- HOLD (`req`=0): while stall, hold everything. When stall=0: outputs<=skid, `valid_out`<=1, go to FETCH.
- Redirect has priority over stall and over ack, in every state:
  - Outputs<=bubble.
  - FETCH with ack this cycle: discard the data, `pc`<=redirect_pc, stay in FETCH.
  - FETCH without ack: `pending_pc`<=redirect_pc, go to DRAIN. The outstanding request cannot be withdrawn.
  - HOLD: discard the skid, `pc`<=redirect_pc, go to FETCH.
  - DRAIN: `pending_pc`<=redirect_pc (newest target wins).
- DRAIN: keep `req` high at the old address. On ack, discard the data, `pc`<=pending_pc, go to FETCH. Outputs stay bubble while in DRAIN regardless of stall.
- PC arithmetic: 32-bit modulo 2^32; 32'hFFFFFFFF + 1 wraps to 0 silently.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - state=IDLE, `pc`=RESET_PC, `pending_pc`=0, skid=0.
  - `imem_req`=0, `instr_out`=NOP_INSTR, `pc_out`=0, `valid_out`=0.
- Reset asserted mid-transaction drops `req` immediately; memory must abandon the request.
- First request: first rising edge after release enters FETCH. `imem_req`=1 with addr RESET_PC from then on.
- Latency: ack in cycle N gives the instruction on `instr_out` after edge N.
- Throughput: 1 instr/cycle with zero-wait memory. k wait states give k bubbles per instruction.
- Stall in HOLD: the fetched instruction appears the cycle after stall falls. Refetch is issued the same cycle.
- Redirect bubbles: at least 1 bubble cycle. The target's first fetch starts the cycle after the redirect (or after the drain ack).

## Test plan
- Reset then zero-wait memory (ack=1 always, rdata=addr+32'h100): `pc_out`=0,1,2,3 and `instr_out`=100,101,102,103 on consecutive cycles, `valid_out`=1 from the 2nd cycle after release.
- Two wait states per access: `valid_out` pattern 0,0,1 repeating; `imem_addr` stable across the wait cycles.
- Stall for 3 cycles coinciding with ack at addr 5:
  - Outputs hold at addr 4; `req` is 0 in HOLD.
  - After stall falls, `pc_out`=5 then 6.
  - No instruction is lost or duplicated.
- Redirect to 32'h40 while the request at addr 7 is still waiting (ack 2 cycles later):
  - DRAIN keeps addr 7 until ack; the data is discarded.
  - The next request is 32'h40; the first valid `pc_out` is 32'h40; no valid `pc_out`=7 appears.
- Redirect and ack in the same cycle, with stall=1: bubble output, next `imem_addr`=redirect_pc, stall ignored for the flush.
- Reset mid-operation:
  - `rst_n` low asynchronously between edges: `imem_req`, `valid_out`, `instr_out`, `pc_out` take reset values immediately.
  - After release, fetch restarts at RESET_PC. Also cover the PC wrap from 32'hFFFFFFFF to 0.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC and fetches over a req/ack imem handshake.
// It feeds instr/pc to the IF/ID buffer, emitting NOP bubbles with valid_out=0.
// A one-entry skid buffer holds a word that arrives during a decode stall.
// DRAIN lets an unwithdrawable request finish after a redirect.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0,
   parameter logic [31:0] PC_STEP   = 32'h1,
   parameter logic [31:0] NOP_INSTR = 32'h0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr_out,
   output logic [31:0] pc_out,
   output logic        valid_out
);

   typedef enum logic [1:0] {StIdle, StFetch, StHold, StDrain} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pending_q, pending_d;
   logic [31:0] skid_instr_q, skid_instr_d;
   logic [31:0] skid_pc_q, skid_pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_out_q, pc_out_d;
   logic        valid_q, valid_d;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath registers: PC, redirect target, skid entry and IF/ID outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q         <= RESET_PC;
         pending_q    <= 32'h0;
         skid_instr_q <= 32'h0;
         skid_pc_q    <= 32'h0;
         instr_q      <= NOP_INSTR;
         pc_out_q     <= 32'h0;
         valid_q      <= 1'b0;
      end else begin
         pc_q         <= pc_d;
         pending_q    <= pending_d;
         skid_instr_q <= skid_instr_d;
         skid_pc_q    <= skid_pc_d;
         instr_q      <= instr_d;
         pc_out_q     <= pc_out_d;
         valid_q      <= valid_d;
      end
   end

   // Next-state logic; redirect outranks stall and ack
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  state_d = StFetch;
         StFetch: begin
            if (redirect_valid) begin
               // an unacked request cannot be withdrawn, so wait it out in DRAIN
               state_d = imem_ack ? StFetch : StDrain;
            end else if (imem_ack && stall) begin
               state_d = StHold;
            end
         end
         StHold:  if (redirect_valid || !stall) state_d = StFetch;
         StDrain: if (imem_ack) state_d = StFetch;
         default: state_d = StIdle;
      endcase
   end

   // Datapath next-state: PC advance, skid capture and IF/ID output updates
   always_comb begin
      pc_d         = pc_q;
      pending_d    = pending_q;
      skid_instr_d = skid_instr_q;
      skid_pc_d    = skid_pc_q;
      instr_d      = instr_q;
      pc_out_d     = pc_out_q;
      valid_d      = valid_q;
      if (redirect_valid) begin
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
      end
      unique case (state_q)
         StIdle: begin
            if (redirect_valid) pc_d = redirect_pc;
         end
         StFetch: begin
            if (redirect_valid) begin
               if (imem_ack) pc_d = redirect_pc;
               else          pending_d = redirect_pc;
            end else if (imem_ack) begin
               pc_d = pc_q + PC_STEP;
               if (stall) begin
                  skid_instr_d = imem_rdata;
                  skid_pc_d    = pc_q;
               end else begin
                  instr_d  = imem_rdata;
                  pc_out_d = pc_q;
                  valid_d  = 1'b1;
               end
            end else if (!stall) begin
               instr_d = NOP_INSTR;
               valid_d = 1'b0;
            end
         end
         StHold: begin
            if (redirect_valid) begin
               pc_d = redirect_pc;
            end else if (!stall) begin
               instr_d  = skid_instr_q;
               pc_out_d = skid_pc_q;
               valid_d  = 1'b1;
            end
         end
         StDrain: begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            if (redirect_valid) begin
               // newest target wins, even when it coincides with the drain ack
               pending_d = redirect_pc;
               if (imem_ack) pc_d = redirect_pc;
            end else if (imem_ack) begin
               pc_d = pending_q;
            end
         end
         default: ;
      endcase
   end

   // Outputs decoded from state and registers
   always_comb begin
      imem_req  = (state_q == StFetch) || (state_q == StDrain);
      imem_addr = pc_q;
      instr_out = instr_q;
      pc_out    = pc_out_q;
      valid_out = valid_q;
   end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: randomized wait-state memory, stalls and redirects.
// A scoreboard holds the next expected instruction address of the program stream.
module tb_if_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic [31:0] instr_out;
   logic [31:0] pc_out;
   logic        valid_out;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] exp_q[$];
   int          new_cnt = 0;
   int          idle_cycles = 0;
   int          wait_mode = 0;     // fixed wait states, or -1 for random 0..2
   bit          mem_busy = 1'b0;
   int          wait_left = 0;
   logic [31:0] addr_lat = 32'h0;
   logic [31:0] e;

   always #5 clk = ~clk;

   if_fetch_stage dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .instr_out      (instr_out),
      .pc_out         (pc_out),
      .valid_out      (valid_out)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a + 32'h100;
   endfunction

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Memory: latches the address at request start, answers after the wait count
   always @(negedge clk) begin
      if (!rst_n || imem_req !== 1'b1) begin
         mem_busy = 1'b0;
         imem_ack = 1'b0;
      end else begin
         if (!mem_busy) begin
            mem_busy = 1'b1;
            addr_lat = imem_addr;
            wait_left = (wait_mode < 0) ? int'($urandom_range(2, 0)) : wait_mode;
         end else begin
            check32("addr_stable", imem_addr, addr_lat);
         end
         if (wait_left == 0) begin
            imem_ack   = 1'b1;
            imem_rdata = mem_word(imem_addr);
            mem_busy   = 1'b0;
         end else begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            wait_left--;
         end
      end
   end

   // Monitor: every instruction accepted by IF/ID must be the next program word
   always @(posedge clk) begin
      #1;
      if (rst_n) begin
         if (valid_out === 1'b1 && stall === 1'b0) begin
            new_cnt++;
            idle_cycles = 0;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_instr: got pc %h expected none", pc_out);
            end else begin
               e = exp_q.pop_front();
               check32("pc_out", pc_out, e);
               check32("instr_out", instr_out, mem_word(e));
               exp_q.push_back(e + 32'd1);
            end
         end else begin
            idle_cycles++;
            if (idle_cycles > 100) begin
               checks++;
               failures++;
               $display("FAIL watchdog: got %0d idle cycles expected at most 100", idle_cycles);
               idle_cycles = 0;
            end
         end
      end
   end

   task automatic do_redirect(input logic [31:0] tgt);
      redirect_valid = 1'b1;
      redirect_pc    = tgt;
      exp_q.delete();
      exp_q.push_back(tgt);
   endtask

   // Reset asserted between edges; outputs must drop at once
   task automatic apply_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      stall = 1'b0;
      redirect_valid = 1'b0;
      #1;
      check32("rst_req", {31'h0, imem_req}, 32'h0);
      check32("rst_valid", {31'h0, valid_out}, 32'h0);
      check32("rst_instr", instr_out, 32'h0);
      check32("rst_pc_out", pc_out, 32'h0);
      exp_q.delete();
      exp_q.push_back(32'h0);
      idle_cycles = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #2;
      check32("first_req", {31'h0, imem_req}, 32'h1);
      check32("first_addr", imem_addr, 32'h0);
      check32("first_valid", {31'h0, valid_out}, 32'h0);
   endtask

   task automatic wait_addr(input logic [31:0] a);
      bit found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         @(negedge clk);
         if (imem_req === 1'b1 && imem_addr === a) found = 1'b1;
      end
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL wait_addr: got no request expected addr %h", a);
      end
   endtask

   int c0;

   initial begin
      #1 rst_n = 1'b0;
      #1;
      check32("init_req", {31'h0, imem_req}, 32'h0);
      check32("init_valid", {31'h0, valid_out}, 32'h0);

      // zero-wait memory: one instruction per cycle
      wait_mode = 0;
      apply_reset();
      @(negedge clk);
      c0 = new_cnt;
      repeat (20) @(negedge clk);
      check32("zero_wait_rate", 32'(new_cnt - c0), 32'd20);

      // two wait states: one instruction every third cycle
      wait_mode = 2;
      apply_reset();
      repeat (3) @(negedge clk);
      c0 = new_cnt;
      repeat (30) @(negedge clk);
      check32("two_wait_rate", 32'(new_cnt - c0), 32'd10);

      // 3-cycle stall coinciding with the ack at addr 5
      wait_mode = 0;
      apply_reset();
      wait_addr(32'd5);
      stall = 1'b1;
      @(posedge clk);
      #2;
      check32("hold_pc", pc_out, 32'd4);
      check32("hold_req", {31'h0, imem_req}, 32'h0);
      repeat (3) @(negedge clk);
      stall = 1'b0;
      @(posedge clk);
      #2;
      check32("skid_pc", pc_out, 32'd5);
      check32("skid_valid", {31'h0, valid_out}, 32'h1);
      check32("refetch_addr", imem_addr, 32'd6);
      @(posedge clk);
      #2;
      check32("after_skid_pc", pc_out, 32'd6);

      // redirect while the request at addr 7 is still waiting
      wait_mode = 2;
      apply_reset();
      wait_addr(32'd7);
      do_redirect(32'h40);
      @(posedge clk);
      #2;
      check32("drain_req", {31'h0, imem_req}, 32'h1);
      check32("drain_addr", imem_addr, 32'd7);
      check32("drain_valid", {31'h0, valid_out}, 32'h0);
      @(negedge clk);
      redirect_valid = 1'b0;
      wait_addr(32'h40);
      repeat (6) @(negedge clk);

      // redirect + ack + stall in one cycle: flush wins
      wait_mode = 0;
      apply_reset();
      repeat (5) @(negedge clk);
      stall = 1'b1;
      do_redirect(32'h80);
      @(posedge clk);
      #2;
      check32("flush_valid", {31'h0, valid_out}, 32'h0);
      check32("flush_addr", imem_addr, 32'h80);
      check32("flush_req", {31'h0, imem_req}, 32'h1);
      @(negedge clk);
      redirect_valid = 1'b0;
      stall = 1'b0;
      repeat (4) @(negedge clk);

      // PC wraps from 32'hFFFFFFFF to 0
      do_redirect(32'hFFFF_FFFE);
      @(negedge clk);
      redirect_valid = 1'b0;
      repeat (3) @(negedge clk);
      check32("wrap_pc", pc_out, 32'h0);
      check32("wrap_valid", {31'h0, valid_out}, 32'h1);

      // random stalls, redirects and wait states, with a reset in the middle
      wait_mode = -1;
      c0 = new_cnt;
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) apply_reset();
         @(negedge clk);
         stall = ($urandom_range(3, 0) == 0);
         if ($urandom_range(19, 0) == 0) begin
            if ($urandom_range(1, 0) == 0) do_redirect($urandom);
            else do_redirect(32'hFFFF_FFFC + 32'($urandom_range(3, 0)));
         end else begin
            redirect_valid = 1'b0;
         end
      end
      @(negedge clk);
      stall = 1'b0;
      redirect_valid = 1'b0;
      repeat (10) @(negedge clk);
      checks++;
      if (new_cnt - c0 < 500) begin
         failures++;
         $display("FAIL random_progress: got %0d instructions expected at least 500", new_cnt - c0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
